// File: rtl/icache_refill_engine_pkg.sv
// Shared parameters, derived widths, FSM state encoding and small slot helpers
// for the I-cache refill engine.
//   No ports; imported by the interface, the beat sequencer and the top.
package icache_refill_engine_pkg;

  localparam int TAG_W         = 8;
  localparam int SET_W         = 4;
  localparam int NUM_WAYS      = 4;
  localparam int WORD_W        = 20;
  localparam int WORDS_PER_BLK = 16;
  localparam int BEAT_WORDS    = 2;

  localparam int OFF_W   = $clog2(WORDS_PER_BLK);
  localparam int BEATS   = WORDS_PER_BLK / BEAT_WORDS;
  // A single-beat block still needs a 1-bit slot/counter field.
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAY_W   = $clog2(NUM_WAYS);
  localparam int BW_LOG  = $clog2(BEAT_WORDS);
  localparam int ADDR_W  = TAG_W + SET_W + OFF_W;
  localparam int BEAT_DW = BEAT_WORDS * WORD_W;

  // Clears the word-within-beat bits of an offset (powers of two only).
  localparam logic [OFF_W-1:0] OFF_BEAT_MASK = OFF_W'(WORDS_PER_BLK - BEAT_WORDS);
  localparam logic [OFF_W-1:0] OFF_WORD_MASK = OFF_W'(BEAT_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_FILL   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  function automatic logic [BEAT_W-1:0] crit_beat_of(input logic [OFF_W-1:0] off);
    return BEAT_W'(off >> BW_LOG);
  endfunction

  function automatic logic [BEAT_W-1:0] wrap_slot(input logic [BEAT_W-1:0] base,
                                                  input logic [BEAT_W-1:0] cnt);
    logic [BEAT_W:0] sum;
    sum = {1'b0, base} + {1'b0, cnt};
    return BEAT_W'(sum % BEATS);
  endfunction

endpackage

// File: rtl/icache_refill_engine_if.sv
// Bus bundle between the refill engine and its neighbours: lookup pipeline
// (miss request), memory (block request and return beats), data array, tag
// array, early-restart word, plus the global halt and busy status.
//   master : the refill engine
//   slave  : the surrounding pipeline / memory / arrays (or a testbench)
interface icache_refill_engine_if;
  import icache_refill_engine_pkg::*;

  logic                i_halt;
  logic                i_miss_valid;
  logic [TAG_W-1:0]    i_miss_tag;
  logic [SET_W-1:0]    i_miss_set;
  logic [OFF_W-1:0]    i_miss_offset;
  logic [WAY_W-1:0]    i_victim_way;
  logic                o_miss_ready;

  logic [ADDR_W-1:0]   o_mem_req_addr;
  logic                o_mem_req_valid;
  logic                i_mem_req_ready;
  logic [BEAT_DW-1:0]  i_mem_data;
  logic                i_mem_data_valid;
  logic                o_mem_data_ready;

  logic                o_da_wr_valid;
  logic [SET_W-1:0]    o_da_set;
  logic [WAY_W-1:0]    o_da_way;
  logic [BEAT_W-1:0]   o_da_beat;
  logic [BEAT_DW-1:0]  o_da_wr_data;
  logic                i_da_wr_ready;

  logic                o_tag_wr_valid;
  logic [SET_W-1:0]    o_tag_set;
  logic [WAY_W-1:0]    o_tag_way;
  logic [TAG_W-1:0]    o_tag_wr_tag;
  logic                i_tag_wr_ready;

  logic [WORD_W-1:0]   o_crit_word;
  logic                o_crit_word_valid;
  logic                o_busy;

  modport master (
    input  i_halt, i_miss_valid, i_miss_tag, i_miss_set, i_miss_offset, i_victim_way,
           i_mem_req_ready, i_mem_data, i_mem_data_valid, i_da_wr_ready, i_tag_wr_ready,
    output o_miss_ready, o_mem_req_addr, o_mem_req_valid, o_mem_data_ready,
           o_da_wr_valid, o_da_set, o_da_way, o_da_beat, o_da_wr_data,
           o_tag_wr_valid, o_tag_set, o_tag_way, o_tag_wr_tag,
           o_crit_word, o_crit_word_valid, o_busy
  );

  modport slave (
    output i_halt, i_miss_valid, i_miss_tag, i_miss_set, i_miss_offset, i_victim_way,
           i_mem_req_ready, i_mem_data, i_mem_data_valid, i_da_wr_ready, i_tag_wr_ready,
    input  o_miss_ready, o_mem_req_addr, o_mem_req_valid, o_mem_data_ready,
           o_da_wr_valid, o_da_set, o_da_way, o_da_beat, o_da_wr_data,
           o_tag_wr_valid, o_tag_set, o_tag_way, o_tag_wr_tag,
           o_crit_word, o_crit_word_valid, o_busy
  );

endinterface

// File: rtl/icache_refill_engine_refill_beat_sequencer.sv
// Beat sequencer for a block refill: counts transferred beats and turns the
// count into the wrap-order slot index starting at the critical beat.
//   clk, arst_n  : clock, async active-low reset
//   i_clear      : restart the count (request handshake)
//   i_advance    : one beat transferred this cycle
//   i_crit_beat  : slot of the first (critical) beat
//   o_slot       : data-array slot for the current beat
//   o_first      : current beat is the first of the block
//   o_last       : current beat is the last of the block
module refill_beat_sequencer
  import icache_refill_engine_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic [BEAT_W-1:0] i_crit_beat,
  output logic [BEAT_W-1:0] o_slot,
  output logic              o_first,
  output logic              o_last
);

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  assign o_first = (beat_cnt_q == '0);
  assign o_last  = (beat_cnt_q == BEAT_W'(BEATS - 1));
  assign o_slot  = wrap_slot(i_crit_beat, beat_cnt_q);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (i_clear) begin
      beat_cnt_d = '0;
    end else if (i_advance) begin
      // Returning to 0 after the last beat keeps the count clean for the
      // next miss even when BEATS is not a full power of the field width.
      beat_cnt_d = o_last ? '0 : beat_cnt_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) beat_cnt_q <= '0;
    else         beat_cnt_q <= beat_cnt_d;
  end

endmodule

// File: rtl/icache_refill_engine.sv
// I-cache miss refill engine. Accepts one miss, issues a critical-beat-first
// block fetch, streams every returned beat straight into the data array,
// forwards the missed word as soon as its beat arrives, and commits the new
// tag only after the whole block is written.
//   clk     : clock
//   arst_n  : asynchronous active-low reset
//   bus     : miss / memory / data-array / tag-array / early-restart bundle
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | waiting for a miss; o_miss_ready = ~i_halt
//   ST_REQ    | block request on the memory port until accepted
//   ST_FILL   | beats streamed into the data array in wrap order
//   ST_COMMIT | tag write of the completed block
module icache_refill_engine
  import icache_refill_engine_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst_n,
  icache_refill_engine_if.master bus
);

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [WORD_W-1:0] crit_word_q, crit_word_d;
  logic              crit_valid_q, crit_valid_d;

  logic              in_fill;
  logic              miss_ready;
  logic              tag_wr_valid;
  logic              miss_fire, req_fire, beat_fire, commit_fire;
  logic [BEAT_W-1:0] slot;
  logic              first_beat, last_beat;
  logic [OFF_W-1:0]  word_sel;
  logic [WORD_W-1:0] crit_pick;

  assign in_fill      = (state_q == ST_FILL);
  assign miss_ready   = (state_q == ST_IDLE) && !bus.i_halt;
  assign tag_wr_valid = (state_q == ST_COMMIT) && !bus.i_halt;

  assign miss_fire   = miss_ready && bus.i_miss_valid;
  // The request cannot be withdrawn once raised, so an acceptance seen while
  // halted still counts; otherwise memory would answer a request we forgot.
  assign req_fire    = (state_q == ST_REQ) && bus.i_mem_req_ready;
  assign beat_fire   = in_fill && bus.i_mem_data_valid && bus.i_da_wr_ready && !bus.i_halt;
  assign commit_fire = tag_wr_valid && bus.i_tag_wr_ready;

  refill_beat_sequencer u_seq (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_clear     (req_fire),
    .i_advance   (beat_fire),
    .i_crit_beat (crit_beat_of(off_q)),
    .o_slot      (slot),
    .o_first     (first_beat),
    .o_last      (last_beat)
  );

  assign word_sel  = off_q & OFF_WORD_MASK;
  assign crit_pick = bus.i_mem_data[int'(word_sel)*WORD_W +: WORD_W];

  assign bus.o_miss_ready      = miss_ready;
  assign bus.o_busy            = (state_q != ST_IDLE);
  assign bus.o_mem_req_valid   = (state_q == ST_REQ);
  assign bus.o_mem_req_addr    = {tag_q, set_q, off_q & OFF_BEAT_MASK};
  assign bus.o_mem_data_ready  = in_fill && bus.i_da_wr_ready && !bus.i_halt;
  assign bus.o_da_wr_valid     = in_fill && bus.i_mem_data_valid && !bus.i_halt;
  assign bus.o_da_set          = set_q;
  assign bus.o_da_way          = way_q;
  assign bus.o_da_beat         = slot;
  // Gated so stray memory data never shows on the array bus outside FILL.
  assign bus.o_da_wr_data      = in_fill ? bus.i_mem_data : '0;
  assign bus.o_tag_wr_valid    = tag_wr_valid;
  assign bus.o_tag_set         = set_q;
  assign bus.o_tag_way         = way_q;
  assign bus.o_tag_wr_tag      = tag_q;
  assign bus.o_crit_word       = crit_word_q;
  assign bus.o_crit_word_valid = crit_valid_q;

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    set_d        = set_q;
    off_d        = off_q;
    way_d        = way_q;
    crit_word_d  = crit_word_q;
    crit_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_fire) begin
          tag_d   = bus.i_miss_tag;
          set_d   = bus.i_miss_set;
          off_d   = bus.i_miss_offset;
          way_d   = bus.i_victim_way;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (req_fire) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (beat_fire) begin
          if (first_beat) begin
            crit_word_d  = crit_pick;
            crit_valid_d = 1'b1;
          end
          if (last_beat) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (commit_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      set_q        <= '0;
      off_q        <= '0;
      way_q        <= '0;
      crit_word_q  <= '0;
      crit_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      set_q        <= set_d;
      off_q        <= off_d;
      way_q        <= way_d;
      crit_word_q  <= crit_word_d;
      crit_valid_q <= crit_valid_d;
    end
  end

endmodule

// File: tb/tb_icache_refill_engine.sv
// Randomized self-checking bench for icache_refill_engine. A per-miss
// reference computes request address, wrap-order slots, crit word and tag
// commit from the miss fields with plain arithmetic.
module tb_icache_refill_engine;
  import icache_refill_engine_pkg::*;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  icache_refill_engine_if bus_if ();

  icache_refill_engine dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus_if)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus_if.i_halt           = 1'b0;
    bus_if.i_miss_valid     = 1'b0;
    bus_if.i_mem_req_ready  = 1'b0;
    bus_if.i_mem_data_valid = 1'b0;
    bus_if.i_da_wr_ready    = 1'b0;
    bus_if.i_tag_wr_ready   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_miss_ready"}, 64'(bus_if.o_miss_ready), 64'(!bus_if.i_halt));
    check_eq({pfx, "_busy"},       64'(bus_if.o_busy), 0);
    check_eq({pfx, "_req_valid"},  64'(bus_if.o_mem_req_valid), 0);
    check_eq({pfx, "_req_addr"},   64'(bus_if.o_mem_req_addr), 0);
    check_eq({pfx, "_mem_rdy"},    64'(bus_if.o_mem_data_ready), 0);
    check_eq({pfx, "_da_valid"},   64'(bus_if.o_da_wr_valid), 0);
    check_eq({pfx, "_da_set"},     64'(bus_if.o_da_set), 0);
    check_eq({pfx, "_da_way"},     64'(bus_if.o_da_way), 0);
    check_eq({pfx, "_da_beat"},    64'(bus_if.o_da_beat), 0);
    check_eq({pfx, "_da_data"},    64'(bus_if.o_da_wr_data), 0);
    check_eq({pfx, "_tag_valid"},  64'(bus_if.o_tag_wr_valid), 0);
    check_eq({pfx, "_tag_tag"},    64'(bus_if.o_tag_wr_tag), 0);
    check_eq({pfx, "_crit_valid"}, 64'(bus_if.o_crit_word_valid), 0);
    check_eq({pfx, "_crit_word"},  64'(bus_if.o_crit_word), 0);
  endtask

  // Reference: word address of the critical beat = {tag, set, crit_beat, 0}.
  function automatic longint exp_addr(input int tag, input int set, input int off);
    return (longint'(tag) << (SET_W + OFF_W)) | (longint'(set) << OFF_W)
         | longint'((off / BEAT_WORDS) * BEAT_WORDS);
  endfunction

  // One miss end to end. stall_at: beat index where the data array stalls
  // 3 cycles (-1 none); halts: halt during REQ wait and COMMIT; gaps: random
  // handshake gaps and occasional halts in FILL; abort_after: reset once this
  // many beats are written (-1 none).
  task automatic run_miss(input int tag, input int set, input int off, input int way,
                          input int stall_at, input bit halts, input bit gaps,
                          input int abort_after);
    logic [BEAT_DW-1:0] beats [BEATS];
    int  k, cycles, wait_n, hold, stall_left;
    bit  pend_crit, dv, rdy, h, xfer;
    longint crit_exp;
    for (int b = 0; b < BEATS; b++) beats[b] = BEAT_DW'({$urandom(), $urandom()});
    crit_exp = longint'((beats[0] >> ((off % BEAT_WORDS) * WORD_W)) & ((64'd1 << WORD_W) - 1));

    @(negedge clk);
    bus_if.i_miss_valid  = 1'b1;
    bus_if.i_miss_tag    = TAG_W'(tag);
    bus_if.i_miss_set    = SET_W'(set);
    bus_if.i_miss_offset = OFF_W'(off);
    bus_if.i_victim_way  = WAY_W'(way);
    #1 check_eq("miss_ready", 64'(bus_if.o_miss_ready), 1);

    // REQ: scramble the miss inputs to confirm they were latched.
    wait_n = halts ? 3 : (gaps ? int'($urandom_range(0, 3)) : 0);
    for (int c = 0; c <= wait_n; c++) begin
      @(negedge clk);
      bus_if.i_miss_valid     = 1'b0;
      bus_if.i_miss_tag       = TAG_W'($urandom());
      bus_if.i_miss_offset    = OFF_W'($urandom());
      bus_if.i_halt           = halts && (c < wait_n);
      bus_if.i_mem_data_valid = 1'($urandom_range(0, 1));
      bus_if.i_da_wr_ready    = 1'b1;
      bus_if.i_mem_req_ready  = (c == wait_n);
      #1;
      check_eq("req_valid", 64'(bus_if.o_mem_req_valid), 1);
      check_eq("req_addr", 64'(bus_if.o_mem_req_addr), 64'(exp_addr(tag, set, off)));
      check_eq("req_da_valid", 64'(bus_if.o_da_wr_valid), 0);
      check_eq("req_mem_rdy", 64'(bus_if.o_mem_data_ready), 0);
      check_eq("req_busy", 64'(bus_if.o_busy), 1);
    end
    bus_if.i_halt = 1'b0;

    // FILL
    k = 0; cycles = 0; pend_crit = 1'b0; stall_left = 3;
    while (k < BEATS) begin
      @(negedge clk);
      bus_if.i_mem_req_ready = 1'b0;
      if (abort_after >= 0 && k == abort_after) begin
        bus_if.i_mem_data_valid = 1'b1;
        arst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        arst_n = 1'b1;
        idle_inputs();
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          bus_if.i_tag_wr_ready = 1'b1;
          #1;
          check_eq("post_abort_tag", 64'(bus_if.o_tag_wr_valid), 0);
          check_eq("post_abort_crit", 64'(bus_if.o_crit_word_valid), 0);
          check_eq("post_abort_busy", 64'(bus_if.o_busy), 0);
        end
        idle_inputs();
        return;
      end
      dv  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall_at == k && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      h = gaps && ($urandom_range(0, 9) == 0);
      bus_if.i_mem_data_valid = dv;
      bus_if.i_da_wr_ready    = rdy;
      bus_if.i_halt           = h;
      bus_if.i_mem_data       = dv ? beats[k] : BEAT_DW'({$urandom(), $urandom()});
      xfer = dv && rdy && !h;
      #1;
      check_eq("fill_mem_rdy", 64'(bus_if.o_mem_data_ready), 64'(rdy && !h));
      check_eq("fill_da_valid", 64'(bus_if.o_da_wr_valid), 64'(dv && !h));
      if (dv && !h) begin
        check_eq("fill_slot", 64'(bus_if.o_da_beat), 64'(((off / BEAT_WORDS) + k) % BEATS));
        check_eq("fill_set", 64'(bus_if.o_da_set), 64'(set));
        check_eq("fill_way", 64'(bus_if.o_da_way), 64'(way));
        check_eq("fill_data", 64'(bus_if.o_da_wr_data), 64'(beats[k]));
      end
      check_eq("fill_crit_valid", 64'(bus_if.o_crit_word_valid), 64'(pend_crit));
      if (pend_crit) check_eq("fill_crit_word", 64'(bus_if.o_crit_word), 64'(crit_exp));
      pend_crit = xfer && (k == 0);
      if (xfer) k++;
      cycles++;
      if (cycles > 400) begin
        check_eq("fill_timeout_beats", 64'(k), 64'(BEATS));
        break;
      end
    end
    bus_if.i_halt = 1'b0;

    // COMMIT
    hold = halts ? 2 : (gaps ? int'($urandom_range(0, 2)) : 0);
    for (int c = 0; c <= hold; c++) begin
      @(negedge clk);
      bus_if.i_mem_data_valid = 1'($urandom_range(0, 1));
      bus_if.i_da_wr_ready    = 1'b1;
      bus_if.i_halt           = halts && (c < hold);
      bus_if.i_tag_wr_ready   = halts ? 1'b1 : (c == hold);
      #1;
      check_eq("commit_valid", 64'(bus_if.o_tag_wr_valid), 64'(!bus_if.i_halt));
      check_eq("commit_set", 64'(bus_if.o_tag_set), 64'(set));
      check_eq("commit_way", 64'(bus_if.o_tag_way), 64'(way));
      check_eq("commit_tag", 64'(bus_if.o_tag_wr_tag), 64'(tag));
      check_eq("commit_da_valid", 64'(bus_if.o_da_wr_valid), 0);
      check_eq("commit_crit_valid", 64'(bus_if.o_crit_word_valid), 64'(pend_crit));
      pend_crit = 1'b0;
    end

    @(negedge clk);
    idle_inputs();
    #1;
    check_eq("done_busy", 64'(bus_if.o_busy), 0);
    check_eq("done_miss_ready", 64'(bus_if.o_miss_ready), 1);
    check_eq("done_tag_valid", 64'(bus_if.o_tag_wr_valid), 0);
  endtask

  initial begin
    idle_inputs();
    bus_if.i_miss_tag    = '0;
    bus_if.i_miss_set    = '0;
    bus_if.i_miss_offset = '0;
    bus_if.i_victim_way  = '0;
    bus_if.i_mem_data    = '0;
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    arst_n = 1'b1;

    // Directed cases
    run_miss(8'h5A, 3, 0,    2, -1, 1'b0, 1'b0, -1);
    run_miss(8'hC3, 9, 4'hF, 1, -1, 1'b0, 1'b0, -1);
    run_miss(8'h11, 6, 5,    3,  3, 1'b0, 1'b0, -1);
    run_miss(8'h77, 2, 9,    0, -1, 1'b1, 1'b0, -1);
    run_miss(8'h3C, 4, 6,    1, -1, 1'b0, 1'b0,  3);
    run_miss(8'h99, 7, 13,   2, -1, 1'b0, 1'b0, -1);

    // Stray memory data and halted miss while idle
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus_if.i_mem_data_valid = 1'b1;
      bus_if.i_da_wr_ready    = 1'b1;
      bus_if.i_mem_data       = BEAT_DW'({$urandom(), $urandom()});
      bus_if.i_halt           = (c == 3);
      bus_if.i_miss_valid     = (c == 3);
      #1;
      check_eq("idle_da_valid", 64'(bus_if.o_da_wr_valid), 0);
      check_eq("idle_mem_rdy", 64'(bus_if.o_mem_data_ready), 0);
      check_eq("idle_busy", 64'(bus_if.o_busy), 0);
      check_eq("idle_miss_ready", 64'(bus_if.o_miss_ready), 64'(c != 3));
    end
    @(negedge clk);
    idle_inputs();
    #1 check_eq("halted_miss_ignored", 64'(bus_if.o_busy), 0);

    // Randomized misses
    for (int n = 0; n < 40; n++) begin
      run_miss(int'($urandom_range(0, (1 << TAG_W) - 1)),
               int'($urandom_range(0, (1 << SET_W) - 1)),
               int'($urandom_range(0, WORDS_PER_BLK - 1)),
               int'($urandom_range(0, NUM_WAYS - 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1,
               1'($urandom_range(0, 1)), 1'b1,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, BEATS - 1)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
